// File: rtl/vend_ctrl_pkg.sv
// vend_ctrl_pkg
//   Shared definitions for the vending transaction controller: the state
//   encoding that the display block decodes, default item prices, the
//   default DONE dwell time and the coin-value helper.
package vend_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SELECT = 2'b01,
    S_PAY    = 2'b10,
    S_DONE   = 2'b11
  } state_e;

  localparam logic [7:0]  PRICE0_DEF   = 8'd3;
  localparam logic [7:0]  PRICE1_DEF   = 8'd5;
  localparam logic [7:0]  PRICE2_DEF   = 8'd10;
  localparam logic [7:0]  PRICE3_DEF   = 8'd20;
  localparam int unsigned DONE_CYC_DEF = 500;

  localparam logic [8:0] COIN1_VAL  = 9'd1;
  localparam logic [8:0] COIN10_VAL = 9'd10;

  // Value of the coins that arrived this cycle; both together add 11.
  function automatic logic [8:0] coin_sum(input logic c1, input logic c10);
    coin_sum = (c1 ? COIN1_VAL : 9'd0) + (c10 ? COIN10_VAL : 9'd0);
  endfunction

endpackage

// File: rtl/vend_ctrl_btn_edge.sv
// vend_ctrl_btn_edge
//   Single-bit rising-edge detector for a raw button/coin level.
//   Ports:
//     clk_i   in  1  clock
//     rst_i   in  1  synchronous active-high reset (previous level -> 0)
//     lvl_i   in  1  raw level
//     rise_o  out 1  high in the cycle where lvl_i is 1 and was 0 last cycle
//   Because the stored level resets to 0, a level held high through reset
//   produces exactly one pulse once reset is released.
module vend_ctrl_btn_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic lvl_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) prev_q <= 1'b0;
    else       prev_q <= lvl_i;
  end

  assign rise_o = lvl_i & ~prev_q;

endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl
//   Vending front-panel transaction controller. Edge-detects the raw panel
//   inputs, runs the session FSM, keeps the saturating credit register,
//   selects the item price, debits on confirm, refunds on cancel and times
//   out of DONE after DONE_CYC cycles.
//   Ports:
//     clk_N        in   1  clock, rising edge
//     rst          in   1  synchronous reset, active-high
//     start_btn    in   1  start session (level)
//     coin1        in   1  +1 unit coin (level)
//     coin10       in   1  +10 unit coin (level)
//     sel          in   2  item index, taken on sel_btn rising edge
//     sel_btn      in   1  latch item selection (level)
//     confirm_btn  in   1  confirm purchase (level)
//     cancel_btn   in   1  abort and refund (level)
//     state        out  2  00 IDLE, 01 SELECT, 10 PAY, 11 DONE
//     cost         out  8  price of selected item, 0 = none
//     left         out  8  current credit
//     press        out  1  1-cycle pulse, purchase accepted
//     cancel_flag  out  1  1-cycle pulse, session cancelled
//     refund       out  8  credit returned at the last cancel
//     short_pay    out  1  1-cycle pulse, confirm rejected
module vend_ctrl
  import vend_ctrl_pkg::*;
#(
  parameter logic [7:0]  PRICE0   = PRICE0_DEF,
  parameter logic [7:0]  PRICE1   = PRICE1_DEF,
  parameter logic [7:0]  PRICE2   = PRICE2_DEF,
  parameter logic [7:0]  PRICE3   = PRICE3_DEF,
  parameter int unsigned DONE_CYC = DONE_CYC_DEF
) (
  input  logic       clk_N,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       coin1,
  input  logic       coin10,
  input  logic [1:0] sel,
  input  logic       sel_btn,
  input  logic       confirm_btn,
  input  logic       cancel_btn,
  output logic [1:0] state,
  output logic [7:0] cost,
  output logic [7:0] left,
  output logic       press,
  output logic       cancel_flag,
  output logic [7:0] refund,
  output logic       short_pay
);

  localparam int TW = $clog2(DONE_CYC);
  localparam logic [TW-1:0] T_LAST = TW'(DONE_CYC - 1);

  localparam int E_START   = 0;
  localparam int E_COIN1   = 1;
  localparam int E_COIN10  = 2;
  localparam int E_SEL     = 3;
  localparam int E_CONFIRM = 4;
  localparam int E_CANCEL  = 5;

  logic [5:0] lvl;
  logic [5:0] rise;

  assign lvl = {cancel_btn, confirm_btn, sel_btn, coin10, coin1, start_btn};

  for (genvar g = 0; g < 6; g++) begin : g_edge
    vend_ctrl_btn_edge u_edge (
      .clk_i  (clk_N),
      .rst_i  (rst),
      .lvl_i  (lvl[g]),
      .rise_o (rise[g])
    );
  end

  // Credit never wraps: the 9-bit sum clamps at 8'hFF.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [8:0] b);
    logic [8:0] s;
    s = {1'b0, a} + b;
    sat_add = s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [7:0] price_of(input logic [1:0] idx);
    unique case (idx)
      2'd0:    price_of = PRICE0;
      2'd1:    price_of = PRICE1;
      2'd2:    price_of = PRICE2;
      default: price_of = PRICE3;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic [7:0]      cost_q, cost_d;
  logic [7:0]      left_q, left_d;
  logic [7:0]      refund_q, refund_d;
  logic            press_q, press_d;
  logic            cancel_q, cancel_d;
  logic            short_q, short_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      credit;

  // Only the highest-priority event acts in a cycle:
  // cancel > confirm > sel > coins. Coins are dropped whenever a
  // higher-priority button fires in the same cycle.
  always_comb begin
    state_d  = state_q;
    cost_d   = cost_q;
    left_d   = left_q;
    refund_d = refund_q;
    timer_d  = timer_q;
    press_d  = 1'b0;
    cancel_d = 1'b0;
    short_d  = 1'b0;
    credit   = sat_add(left_q, coin_sum(rise[E_COIN1], rise[E_COIN10]));

    if (state_q == S_IDLE) begin
      if (rise[E_START]) state_d = S_SELECT;
    end else if (rise[E_CANCEL]) begin
      refund_d = left_q;
      left_d   = 8'd0;
      cost_d   = 8'd0;
      cancel_d = 1'b1;
      state_d  = S_IDLE;
    end else if (rise[E_CONFIRM]) begin
      if (state_q == S_PAY) begin
        if (cost_q != 8'd0 && left_q >= cost_q) begin
          left_d  = left_q - cost_q;
          press_d = 1'b1;
          state_d = S_DONE;
          timer_d = '0;
        end else begin
          short_d = 1'b1;
        end
      end else if (state_q == S_DONE) begin
        state_d = S_PAY;
      end
    end else if (rise[E_SEL]) begin
      cost_d  = price_of(sel);
      state_d = S_PAY;
    end else begin
      left_d = credit;
      if (state_q == S_DONE) begin
        // Timeout decision uses the credit including this cycle's coins.
        if (timer_q == T_LAST) begin
          if (credit != 8'd0) begin
            state_d = S_SELECT;
          end else begin
            state_d = S_IDLE;
            cost_d  = 8'd0;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_N) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cost_q   <= 8'd0;
      left_q   <= 8'd0;
      refund_q <= 8'd0;
      press_q  <= 1'b0;
      cancel_q <= 1'b0;
      short_q  <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      cost_q   <= cost_d;
      left_q   <= left_d;
      refund_q <= refund_d;
      press_q  <= press_d;
      cancel_q <= cancel_d;
      short_q  <= short_d;
      timer_q  <= timer_d;
    end
  end

  assign state       = state_q;
  assign cost        = cost_q;
  assign left        = left_q;
  assign refund      = refund_q;
  assign press       = press_q;
  assign cancel_flag = cancel_q;
  assign short_pay   = short_q;

endmodule

// File: tb/tb_vend_ctrl.sv
module tb_vend_ctrl;

  localparam int DONE_CYC = 8;
  localparam int ST = 0, C1 = 1, C10 = 2, SB = 3, CF = 4, CN = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_btn = 0, coin1 = 0, coin10 = 0, sel_btn = 0;
  logic       confirm_btn = 0, cancel_btn = 0;
  logic [1:0] sel = 2'd0;
  logic [1:0] state;
  logic [7:0] cost, left, refund;
  logic       press, cancel_flag, short_pay;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state (plain integers)
  int m_state, m_cost, m_left, m_refund, m_tcnt;
  int m_press, m_cf, m_sp;
  bit p_st, p_c1, p_c10, p_sb, p_cf, p_cn;
  int prices[4] = '{3, 5, 10, 20};

  vend_ctrl #(.DONE_CYC(DONE_CYC)) dut (
    .clk_N(clk), .rst(rst), .start_btn(start_btn), .coin1(coin1),
    .coin10(coin10), .sel(sel), .sel_btn(sel_btn), .confirm_btn(confirm_btn),
    .cancel_btn(cancel_btn), .state(state), .cost(cost), .left(left),
    .press(press), .cancel_flag(cancel_flag), .refund(refund),
    .short_pay(short_pay)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit e_st, e_c1, e_c10, e_sb, e_cf, e_cn;
    int add;
    if (rst) begin
      m_state = 0; m_cost = 0; m_left = 0; m_refund = 0; m_tcnt = 0;
      m_press = 0; m_cf = 0; m_sp = 0;
      {p_st, p_c1, p_c10, p_sb, p_cf, p_cn} = '0;
      return;
    end
    e_st = start_btn && !p_st;   e_c1 = coin1 && !p_c1;
    e_c10 = coin10 && !p_c10;    e_sb = sel_btn && !p_sb;
    e_cf = confirm_btn && !p_cf; e_cn = cancel_btn && !p_cn;
    p_st = start_btn; p_c1 = coin1; p_c10 = coin10;
    p_sb = sel_btn; p_cf = confirm_btn; p_cn = cancel_btn;
    m_press = 0; m_cf = 0; m_sp = 0;
    add = (e_c1 ? 1 : 0) + (e_c10 ? 10 : 0);
    if (m_state == 0) begin
      if (e_st) m_state = 1;
    end else if (e_cn) begin
      m_refund = m_left; m_left = 0; m_cost = 0; m_cf = 1; m_state = 0;
    end else if (e_cf) begin
      if (m_state == 2) begin
        if (m_cost != 0 && m_left >= m_cost) begin
          m_left -= m_cost; m_press = 1; m_state = 3; m_tcnt = 0;
        end else m_sp = 1;
      end else if (m_state == 3) m_state = 2;
    end else if (e_sb) begin
      m_cost = prices[sel]; m_state = 2;
    end else begin
      m_left = (m_left + add > 255) ? 255 : m_left + add;
      if (m_state == 3) begin
        if (m_tcnt == DONE_CYC - 1) begin
          if (m_left != 0) m_state = 1;
          else begin m_state = 0; m_cost = 0; end
        end else m_tcnt++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("state", state, m_state);
    chk("cost", cost, m_cost);
    chk("left", left, m_left);
    chk("refund", refund, m_refund);
    chk("press", press, m_press);
    chk("cancel_flag", cancel_flag, m_cf);
    chk("short_pay", short_pay, m_sp);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic set(input int which, input logic v);
    case (which)
      ST:  start_btn = v;
      C1:  coin1 = v;
      C10: coin10 = v;
      SB:  sel_btn = v;
      CF:  confirm_btn = v;
      default: cancel_btn = v;
    endcase
  endtask

  task automatic hit(input int which);
    set(which, 1'b1); tick();
    set(which, 1'b0); tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  initial begin
    // 1: basic purchase
    do_reset();
    chk("rst_state", state, 0);
    chk("rst_left", left, 0);
    hit(ST);
    chk("t1_select", state, 1);
    hit(C1); hit(C1); hit(C10);
    chk("t1_left12", left, 12);
    sel = 2'd0; hit(SB);
    chk("t1_pay", state, 2);
    chk("t1_cost3", cost, 3);
    set(CF, 1); tick();
    chk("t1_press", press, 1);
    chk("t1_done", state, 3);
    chk("t1_left9", left, 9);
    chk("t1_nosp", short_pay, 0);
    set(CF, 0); tick();
    chk("t1_press_1cyc", press, 0);

    // 2: short payment
    do_reset();
    hit(ST); repeat (4) hit(C1);
    sel = 2'd2; hit(SB);
    set(CF, 1); tick();
    chk("t2_sp", short_pay, 1);
    chk("t2_state", state, 2);
    chk("t2_left4", left, 4);
    chk("t2_cost10", cost, 10);
    chk("t2_nopress", press, 0);
    set(CF, 0); tick();
    chk("t2_sp_1cyc", short_pay, 0);

    // 3: saturation and simultaneous coins
    hit(CN); hit(ST);
    repeat (26) hit(C10);
    chk("t3_sat255", left, 255);
    hit(CN); hit(ST);
    coin1 = 1; coin10 = 1; tick();
    chk("t3_left11", left, 11);
    coin1 = 0; coin10 = 0; tick();

    // 4: cancel beats confirm
    hit(CN); hit(ST);
    repeat (7) hit(C1);
    sel = 2'd0; hit(SB);
    cancel_btn = 1; confirm_btn = 1; tick();
    chk("t4_cf", cancel_flag, 1);
    chk("t4_refund7", refund, 7);
    chk("t4_left0", left, 0);
    chk("t4_cost0", cost, 0);
    chk("t4_idle", state, 0);
    chk("t4_nopress", press, 0);
    cancel_btn = 0; confirm_btn = 0; tick();

    // 5: DONE timeout with and without credit
    hit(ST); repeat (12) hit(C1);
    sel = 2'd0; hit(SB);
    set(CF, 1); tick(); set(CF, 0);
    chk("t5_left9", left, 9);
    for (int i = 1; i <= DONE_CYC; i++) begin
      tick();
      chk("t5_timeout_sel", state, (i < DONE_CYC) ? 3 : 1);
    end
    hit(CN); hit(ST); repeat (3) hit(C1);
    hit(SB);
    set(CF, 1); tick(); set(CF, 0);
    for (int i = 1; i <= DONE_CYC; i++) begin
      tick();
      chk("t5_timeout_idle", state, (i < DONE_CYC) ? 3 : 0);
    end
    chk("t5_cost0", cost, 0);

    // 6: reset mid-session, button held through reset
    hit(ST); repeat (5) hit(C10);
    hit(SB);
    chk("t6_left50", left, 50);
    rst = 1; start_btn = 1; tick();
    chk("t6_rst_left", left, 0);
    chk("t6_rst_cf", cancel_flag, 0);
    chk("t6_rst_state", state, 0);
    tick();
    rst = 0; tick();
    chk("t6_start_once", state, 1);
    tick();
    start_btn = 0; tick();

    // Random phase
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 299) == 0);
      start_btn   = ($urandom_range(0, 3) == 0);
      coin1       = ($urandom_range(0, 2) == 0);
      coin10      = ($urandom_range(0, 2) == 0);
      sel_btn     = ($urandom_range(0, 5) == 0);
      confirm_btn = ($urandom_range(0, 4) == 0);
      cancel_btn  = ($urandom_range(0, 15) == 0);
      sel         = 2'($urandom_range(0, 3));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
